tt_6502_bus_seq: RTL and testbench

//  Sequences every 6502 memory access over the narrow TinyTapeout pin set.

---
 rtl/tt_6502_bus_seq.sv | 151 +++++++++++++++
 tb/tb_tt_6502_bus_seq.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_6502_bus_seq.sv
// tt_6502_bus_seq: sequences 6502 accesses over one shared 8-bit bus.
// Phases are address low, address high, then data. Debug beats CPU.
module tt_6502_bus_seq #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic [15:0] dbg_addr,
  input  logic        dbg_we,
  input  logic [7:0]  dbg_wdata,
  output logic        dbg_ack,
  output logic [7:0]  rd_data,
  output logic        busy,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  input  logic [7:0]  bus_in,
  output logic        bus_ale_lo,
  output logic        bus_ale_hi,
  output logic        bus_rw,
  output logic        bus_strobe
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALO,
    S_AHI,
    S_TURN,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  localparam bit NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [3:0] WAIT_LD =
    NO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        src_q, src_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  rd_q, rd_d;

  // State, latched request and read byte; reset kills the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      src_q   <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state and phase outputs; src=1 marks a debug transaction.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    src_d      = src_q;
    cnt_d      = cnt_q;
    rd_d       = rd_q;
    cpu_ack    = 1'b0;
    dbg_ack    = 1'b0;
    bus_out    = 8'h00;
    bus_oe     = 1'b0;
    bus_ale_lo = 1'b0;
    bus_ale_hi = 1'b0;
    bus_rw     = 1'b1;
    bus_strobe = 1'b0;
    busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        if (ena && (dbg_req || cpu_req)) begin
          state_d = S_ALO;
          src_d   = dbg_req;
          addr_d  = dbg_req ? dbg_addr : cpu_addr;
          we_d    = dbg_req ? dbg_we : cpu_we;
          wdata_d = dbg_req ? dbg_wdata : cpu_wdata;
        end
      end
      S_ALO: begin
        bus_out    = addr_q[7:0];
        bus_oe     = 1'b1;
        bus_ale_lo = 1'b1;
        state_d    = S_AHI;
      end
      S_AHI: begin
        bus_out    = addr_q[15:8];
        bus_oe     = 1'b1;
        bus_ale_hi = 1'b1;
        if (we_q) begin
          state_d = S_WR;
        end else if (NO_WAIT) begin
          state_d = S_RD;
        end else begin
          state_d = S_TURN;
          cnt_d   = WAIT_LD;
        end
      end
      S_TURN: begin
        bus_strobe = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_RD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RD: begin
        bus_strobe = 1'b1;
        rd_d       = bus_in;
        state_d    = S_DONE;
      end
      S_WR: begin
        bus_out    = wdata_q;
        bus_oe     = 1'b1;
        bus_rw     = 1'b0;
        bus_strobe = 1'b1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        cpu_ack = !src_q;
        dbg_ack = src_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_data = rd_q;

endmodule

// File: tb/tb_tt_6502_bus_seq.sv
// tb_tt_6502_bus_seq: two instances (WAIT_CYCLES 1 and 0) checked
// cycle by cycle against a transaction-phase reference model.
module tb_tt_6502_bus_seq;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        ena [2];
  logic        cpu_req [2];
  logic [15:0] cpu_addr [2];
  logic        cpu_we [2];
  logic [7:0]  cpu_wdata [2];
  logic        cpu_ack [2];
  logic        dbg_req [2];
  logic [15:0] dbg_addr [2];
  logic        dbg_we [2];
  logic [7:0]  dbg_wdata [2];
  logic        dbg_ack [2];
  logic [7:0]  rd_data [2];
  logic        busy [2];
  logic [7:0]  bus_out [2];
  logic        bus_oe [2];
  logic [7:0]  bus_in [2];
  logic        bus_ale_lo [2];
  logic        bus_ale_hi [2];
  logic        bus_rw [2];
  logic        bus_strobe [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    tt_6502_bus_seq #(
      .WAIT_CYCLES((g == 0) ? 1 : 0)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena[g]),
      .cpu_req    (cpu_req[g]),
      .cpu_addr   (cpu_addr[g]),
      .cpu_we     (cpu_we[g]),
      .cpu_wdata  (cpu_wdata[g]),
      .cpu_ack    (cpu_ack[g]),
      .dbg_req    (dbg_req[g]),
      .dbg_addr   (dbg_addr[g]),
      .dbg_we     (dbg_we[g]),
      .dbg_wdata  (dbg_wdata[g]),
      .dbg_ack    (dbg_ack[g]),
      .rd_data    (rd_data[g]),
      .busy       (busy[g]),
      .bus_out    (bus_out[g]),
      .bus_oe     (bus_oe[g]),
      .bus_in     (bus_in[g]),
      .bus_ale_lo (bus_ale_lo[g]),
      .bus_ale_hi (bus_ale_hi[g]),
      .bus_rw     (bus_rw[g]),
      .bus_strobe (bus_strobe[g])
    );
  end

  int errors = 0;
  int checks = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: one transaction is a list of phases indexed by k.
  typedef struct {
    bit          act;
    int          k;
    bit          src;
    logic [15:0] addr;
    bit          we;
    logic [7:0]  wd;
    logic [7:0]  rd;
  } mdl_t;

  mdl_t m [2];

  function automatic int wait_of(int i);
    return (i == 0) ? 1 : 0;
  endfunction

  function automatic int len_of(int i);
    return m[i].we ? 4 : 4 + wait_of(i);
  endfunction

  function automatic logic [23:0] expect_outs(int i);
    logic       b, oe, al, ah, rw, st, ca, da;
    logic [7:0] bo;
    int         n, k;
    b = 0; oe = 0; al = 0; ah = 0; rw = 1; st = 0;
    ca = 0; da = 0; bo = 8'h00;
    if (m[i].act) begin
      b = 1;
      n = len_of(i);
      k = m[i].k;
      if (k == 0) begin
        oe = 1; al = 1; bo = m[i].addr[7:0];
      end else if (k == 1) begin
        oe = 1; ah = 1; bo = m[i].addr[15:8];
      end else if (k == n - 1) begin
        if (m[i].src) da = 1;
        else ca = 1;
      end else if (m[i].we) begin
        oe = 1; rw = 0; st = 1; bo = m[i].wd;
      end else begin
        st = 1;
      end
    end
    return {b, oe, al, ah, rw, st, ca, da, bo, m[i].rd};
  endfunction

  function automatic void model_step(int i);
    if (!m[i].act) begin
      if (ena[i] && (dbg_req[i] || cpu_req[i])) begin
        m[i].act  = 1;
        m[i].k    = 0;
        m[i].src  = dbg_req[i];
        m[i].addr = dbg_req[i] ? dbg_addr[i] : cpu_addr[i];
        m[i].we   = dbg_req[i] ? dbg_we[i] : cpu_we[i];
        m[i].wd   = dbg_req[i] ? dbg_wdata[i] : cpu_wdata[i];
      end
    end else begin
      if (!m[i].we && m[i].k == 2 + wait_of(i)) m[i].rd = bus_in[i];
      m[i].k++;
      if (m[i].k == len_of(i)) m[i].act = 0;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].act = 0; m[i].k = 0; m[i].src = 0; m[i].addr = '0;
      m[i].we = 0; m[i].wd = '0; m[i].rd = '0;
    end
  endfunction

  bit rnd = 0;
  bit hold_cpu [2];
  bit saw_cpu [2];
  bit saw_dbg [2];
  int cyc = 0;
  int first_cpu [2];
  int last_cpu [2];
  int last_dbg [2];

  function automatic void clr_acks();
    for (int i = 0; i < 2; i++) begin
      first_cpu[i] = -1; last_cpu[i] = -1; last_dbg[i] = -1;
    end
  endfunction

  function automatic void clr_inputs();
    for (int i = 0; i < 2; i++) begin
      ena[i] = 1; cpu_req[i] = 0; cpu_addr[i] = '0; cpu_we[i] = 0;
      cpu_wdata[i] = '0; dbg_req[i] = 0; dbg_addr[i] = '0;
      dbg_we[i] = 0; dbg_wdata[i] = '0; bus_in[i] = '0;
      hold_cpu[i] = 0;
    end
  endfunction

  // Requester behaviour: drop req after ack, random traffic in rnd mode.
  function automatic void drive(int i);
    if (saw_cpu[i]) begin
      if (hold_cpu[i]) begin
        cpu_we[i] = 1; cpu_wdata[i] = 8'h3C; cpu_addr[i] = 16'h0201;
        hold_cpu[i] = 0;
      end else begin
        cpu_req[i] = 0;
      end
    end else if (rnd && !cpu_req[i] && $urandom_range(0, 3) == 0) begin
      cpu_req[i] = 1;
    end else if (rnd && cpu_req[i] && m[i].act && !m[i].src
                 && $urandom_range(0, 15) == 0) begin
      cpu_req[i] = 0;
    end
    if (saw_dbg[i]) begin
      dbg_req[i] = 0;
    end else if (rnd && !dbg_req[i] && $urandom_range(0, 5) == 0) begin
      dbg_req[i] = 1;
    end else if (rnd && dbg_req[i] && m[i].act && m[i].src
                 && $urandom_range(0, 15) == 0) begin
      dbg_req[i] = 0;
    end
    if (rnd) begin
      cpu_addr[i]  = 16'($urandom);
      cpu_we[i]    = 1'($urandom_range(0, 1));
      cpu_wdata[i] = 8'($urandom);
      dbg_addr[i]  = 16'($urandom);
      dbg_we[i]    = 1'($urandom_range(0, 1));
      dbg_wdata[i] = 8'($urandom);
      bus_in[i]    = 8'($urandom);
      ena[i]       = ($urandom_range(0, 7) != 0);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("outs%0d", i),
            {8'h00, busy[i], bus_oe[i], bus_ale_lo[i], bus_ale_hi[i],
             bus_rw[i], bus_strobe[i], cpu_ack[i], dbg_ack[i],
             bus_out[i], rd_data[i]},
            {8'h00, expect_outs(i)});
      check($sformatf("both_acks%0d", i),
            {31'd0, cpu_ack[i] & dbg_ack[i]}, 32'd0);
      saw_cpu[i] = cpu_ack[i];
      saw_dbg[i] = dbg_ack[i];
      if (cpu_ack[i]) begin
        if (first_cpu[i] < 0) first_cpu[i] = cyc;
        last_cpu[i] = cyc;
      end
      if (dbg_ack[i]) last_dbg[i] = cyc;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) drive(i);
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  int t0;

  initial begin
    rst_n = 0;
    clr_inputs();
    model_reset();
    clr_acks();
    #12;
    for (int i = 0; i < 2; i++)
      check($sformatf("reset%0d", i),
            {8'h00, busy[i], bus_oe[i], bus_ale_lo[i], bus_ale_hi[i],
             bus_rw[i], bus_strobe[i], cpu_ack[i], dbg_ack[i],
             bus_out[i], rd_data[i]},
            32'h0008_0000);
    rst_n = 1;
    @(posedge clk); #1;

    // 1: cpu write 0x1234 <= 0xA5
    clr_acks();
    t0 = cyc + 1;
    cpu_addr[0] = 16'h1234; cpu_we[0] = 1; cpu_wdata[0] = 8'hA5;
    cpu_req[0] = 1;
    run(8);
    check("t1_lat", last_cpu[0] - t0, 4);

    // 2: cpu read 0xFFFC, bus returns 0x5A
    clr_acks();
    t0 = cyc + 1;
    bus_in[0] = 8'h5A;
    cpu_addr[0] = 16'hFFFC; cpu_we[0] = 0; cpu_req[0] = 1;
    run(8);
    check("t2_lat", last_cpu[0] - t0, 5);
    check("t2_rd", {24'd0, rd_data[0]}, 32'h5A);

    // 3: simultaneous requests, debug first
    clr_acks();
    t0 = cyc + 1;
    cpu_addr[0] = 16'h0300; cpu_we[0] = 1; cpu_wdata[0] = 8'h11;
    dbg_addr[0] = 16'h0400; dbg_we[0] = 1; dbg_wdata[0] = 8'h22;
    cpu_req[0] = 1; dbg_req[0] = 1;
    run(14);
    check("t3_dbg_lat", last_dbg[0] - t0, 4);
    check("t3_cpu_lat", last_cpu[0] - t0, 9);

    // 5: ena low blocks the grant
    clr_acks();
    ena[0] = 0;
    cpu_addr[0] = 16'h0010; cpu_we[0] = 0; cpu_req[0] = 1;
    bus_in[0] = 8'h77;
    run(3);
    check("t5_idle", {31'd0, busy[0]}, 32'd0);
    ena[0] = 1;
    t0 = cyc + 1;
    run(1);
    check("t5_alo", {31'd0, bus_ale_lo[0]}, 32'd1);
    run(8);
    check("t5_lat", last_cpu[0] - t0, 5);

    // 6: W=0 read, then held req turns into a write
    clr_acks();
    t0 = cyc + 1;
    bus_in[1] = 8'hC3;
    cpu_addr[1] = 16'h0200; cpu_we[1] = 0; cpu_req[1] = 1;
    hold_cpu[1] = 1;
    run(14);
    check("t6_rd_lat", first_cpu[1] - t0, 4);
    check("t6_wr_lat", last_cpu[1] - t0, 9);
    check("t6_rd", {24'd0, rd_data[1]}, 32'hC3);

    // 4: async reset during TURN
    clr_acks();
    t0 = cyc + 1;
    bus_in[0] = 8'h99;
    cpu_addr[0] = 16'h8000; cpu_we[0] = 0; cpu_req[0] = 1;
    run(3);
    check("t4_busy_pre", {31'd0, busy[0]}, 32'd1);
    check("t4_rd_pre", {24'd0, rd_data[0]}, 32'h77);
    #2 rst_n = 0;
    #1;
    check("t4_oe", {31'd0, bus_oe[0]}, 32'd0);
    check("t4_busy", {31'd0, busy[0]}, 32'd0);
    check("t4_rd", {24'd0, rd_data[0]}, 32'd0);
    check("t4_strobe", {31'd0, bus_strobe[0]}, 32'd0);
    clr_inputs();
    model_reset();
    @(posedge clk); #1;
    check("t4_ack", {31'd0, cpu_ack[0]}, 32'd0);
    check("t4_hold", {31'd0, busy[0]}, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    check("t4_noack", {30'd0, cpu_ack[0], dbg_ack[0]}, 32'd0);

    // randomized traffic on both instances
    clr_acks();
    rnd = 1;
    run(3000);
    rnd = 0;
    for (int i = 0; i < 2; i++) begin
      cpu_req[i] = 0; dbg_req[i] = 0;
    end
    run(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
